led_pwm_fader: RTL and testbench

//  Downstream stage of the rotating-LED pattern generator. Takes the 4-bit on/off

---
 rtl/led_pwm_fader.sv | 94 +++++++++
 tb/tb_led_pwm_fader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// Per-channel PWM LED fader: each channel ramps its brightness linearly toward full or off.
// Optional gamma-corrected duty when LED_PWM_GAMMA_EN is defined.
module led_pwm_ch #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tgt_on,
  input  logic                step,
  input  logic                ld_duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                off_tgt
);
  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] level, duty, duty_nxt;

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq       = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
  assign duty_nxt = sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_nxt = level;
`endif

  assign off_tgt = tgt_on ? (level != MAX) : (level != '0);

  // duty only moves at the period boundary, so a period never sees two duty values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      duty  <= '0;
      led   <= 1'b0;
    end else begin
      if (step) begin
        if (tgt_on && level != MAX)       level <= level + 1'b1;
        else if (!tgt_on && level != '0)  level <= level - 1'b1;
      end
      if (ld_duty) duty <= duty_nxt;
      led <= (pwm_cnt < duty);
    end
  end
endmodule

module led_pwm_fader #(
  parameter int N_CH     = 4,
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 390625
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] led_in,
  output logic [N_CH-1:0] led_out,
  output logic            busy
);
  localparam int FC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FC_W-1:0] FADE_LAST = FC_W'(FADE_DIV - 1);

  logic [FC_W-1:0]     fade_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_CH-1:0]     led_in_q, off_tgt;
  logic                step, ld_duty;

  assign step    = (fade_cnt == FADE_LAST);
  assign ld_duty = &pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fade_cnt <= '0;
      pwm_cnt  <= '0;
      led_in_q <= '0;
      busy     <= 1'b0;
    end else begin
      fade_cnt <= step ? '0 : fade_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      led_in_q <= led_in;
      busy     <= |off_tgt;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tgt_on  (led_in_q[i]),
      .step    (step),
      .ld_duty (ld_duty),
      .pwm_cnt (pwm_cnt),
      .led     (led_out[i]),
      .off_tgt (off_tgt[i])
    );
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: cycle-indexed reference model plus literal fade/PWM expectations.
module tb_led_pwm_fader;
  localparam int N_CH = 4, PB = 4, FD = 2, MAXV = 15, PER = 16;

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] led_in = 4'h0;
  logic [3:0] led_out;
  logic       busy;

  always #5 clk = ~clk;

  led_pwm_fader #(.N_CH(N_CH), .PWM_BITS(PB), .FADE_DIV(FD)) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .led_out(led_out), .busy(busy)
  );

  int total = 0, bad = 0;

  // model state: t = clock edges since reset release; pwm = t%PER, step when t%FD==FD-1
  int         t = 0;
  int         m_lvl [N_CH];
  int         m_duty[N_CH];
  logic [3:0] m_inq = 4'h0, m_out = 4'h0, no_v;
  logic       m_busy = 1'b0, nb_v;

  int pc = 0, pexp = 0, last_pc = 0, periods_done = 0, max_pc = 0;
  bit pvalid = 0;

  function automatic int dload(int l);
`ifdef LED_PWM_GAMMA_EN
    return (l * l) >> PB;
`else
    return l;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin m_lvl[i] = 0; m_duty[i] = 0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < N_CH; i++) begin m_lvl[i] = 0; m_duty[i] = 0; end
        m_inq = 0; m_out = 0; m_busy = 0; t = 0;
      end else begin
        nb_v = 0;
        for (int i = 0; i < N_CH; i++) begin
          no_v[i] = (t % PER) < m_duty[i];
          if (m_lvl[i] != (m_inq[i] ? MAXV : 0)) nb_v = 1;
        end
        if (t % PER == PER - 1)
          for (int i = 0; i < N_CH; i++) m_duty[i] = dload(m_lvl[i]);
        if (t % FD == FD - 1)
          for (int i = 0; i < N_CH; i++) begin
            if (m_inq[i] && m_lvl[i] < MAXV) m_lvl[i]++;
            else if (!m_inq[i] && m_lvl[i] > 0) m_lvl[i]--;
          end
        m_inq = led_in; m_out = no_v; m_busy = nb_v; t++;
      end
    end
  end

  // per-cycle compare plus per-period high-count of channel 0
  initial forever begin
    @(negedge clk);
    check("led_out", led_out, m_out);
    check("busy", busy, m_busy);
    if (!rst && t > 0) begin
      if (t % PER == 1) begin
        pc = led_out[0]; pexp = m_duty[0]; pvalid = 1;
      end else if (pvalid) begin
        pc += led_out[0];
        if (t % PER == 0) begin
          check("period_hi", pc, pexp);
          last_pc = pc; periods_done++; pvalid = 0;
          if (pc > max_pc) max_pc = pc;
        end
      end
    end else pvalid = 0;
  end

  task automatic wait_busy(logic val, int limit, string name);
    int n = 0;
    while (busy !== val && n < limit) begin @(negedge clk); n++; end
    check(name, busy, val);
  endtask

  task automatic wait_periods(int n);
    int start = periods_done, c = 0;
    while (periods_done < start + n && c < 100 * n) begin @(negedge clk); c++; end
    check("period_wait", periods_done >= start + n, 1);
  endtask

  initial begin
    int hi_other, n;
    // reset holds everything low even with all targets on
    led_in = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check("rst_led", led_out, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; led_in = 4'b0001;
    @(negedge clk); @(negedge clk);
    check("busy_rise", busy, 1);
    wait_busy(1'b0, 60, "ramp_up_done");
    check("ramp_up_time", t, 31);
    wait_periods(2);
    check("full_duty_hi", last_pc, 15);
    hi_other = 0;
    repeat (PER) begin @(negedge clk); hi_other |= led_out[3:1]; end
    check("idle_ch_low", hi_other, 0);

    // ramp down to 0
    led_in = 4'b0000;
    wait_busy(1'b1, 4, "down_busy_rise");
    wait_busy(1'b0, 60, "ramp_down_done");
    wait_periods(2);
    check("zero_duty_hi", last_pc, 0);

    // reversal at level 10: turn off when the next edge is not a step
    led_in = 4'b0001;
    n = 0;
    while (!(m_lvl[0] == 10 && t % FD == 0) && n < 60) begin @(negedge clk); n++; end
    check("rev_reach10", m_lvl[0], 10);
    led_in = 4'b0000; max_pc = 0;
    wait_busy(1'b1, 4, "rev_busy");
    wait_busy(1'b0, 40, "rev_done");
    wait_periods(2);
    check("rev_max_le10", max_pc <= 10, 1);
    check("rev_end_hi", last_pc, 0);

    // async reset mid-fade, away from any clock edge
    led_in = 4'hF;
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", led_out, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // random pattern changes
    for (int k = 0; k < 60; k++) begin
      led_in = 4'($urandom);
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end
    led_in = 4'h0;
    repeat (80) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
